// File: rtl/seq_array_mult_ctrl_pkg.sv
// Shared widths, step count and FSM encodings for the sequential 8x8 multiplier.
package seq_array_mult_ctrl_pkg;

    localparam int unsigned OpW      = 8;   // operand width
    localparam int unsigned ProdW    = 16;  // product / accumulator width
    localparam int unsigned NumSteps = 4;   // one 2-bit multiplier slice per step
    localparam int unsigned StepW    = 2;   // step counter width
    localparam int unsigned PpW      = 10;  // 2x8 partial-product row width

    // FSM encodings kept as plain constants for compatibility with older flows
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/pp_row_2x8.sv
// Combinational 2x8 partial-product row: b times a 2-bit multiplier slice.
module pp_row_2x8
    import seq_array_mult_ctrl_pkg::*;
(
    input  logic [1:0]     a2,
    input  logic [OpW-1:0] b,
    output logic [PpW-1:0] pp
);

    // Sum of the two shifted, gated copies of b
    always_comb begin
        pp = ({PpW{a2[0]}} & {2'b00, b})
           + ({PpW{a2[1]}} & {1'b0, b, 1'b0});
    end

endmodule

// File: rtl/seq_array_mult_ctrl.sv
// Sequential 8x8 unsigned multiplier: one 2x8 row reused over four cycles,
// valid/ready on both sides, optional early finish when remaining bits are zero.
module seq_array_mult_ctrl
    import seq_array_mult_ctrl_pkg::*;
#(
    parameter bit EARLY_TERM = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OpW-1:0]   A,
    input  logic [OpW-1:0]   B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ProdW-1:0] P,
    output logic             busy
);

    state_t             state_q, state_d;
    logic [OpW-1:0]     a_q, a_d;
    logic [OpW-1:0]     b_q, b_d;
    logic [ProdW-1:0]   acc_q, acc_d;
    logic [StepW-1:0]   step_q, step_d;

    logic [OpW-1:0]     a_shr;
    logic [1:0]         pair;
    logic               rest_zero;
    logic               last_step;
    logic [PpW-1:0]     pp;
    logic [ProdW-1:0]   pp_shifted;

    // Select the current multiplier slice and look at what is left above it
    always_comb begin
        a_shr      = a_q >> {step_q, 1'b0};
        pair       = a_shr[1:0];
        rest_zero  = (a_shr[OpW-1:2] == '0);
        last_step  = (step_q == StepW'(NumSteps - 1)) || (EARLY_TERM && rest_zero);
        pp_shifted = {{(ProdW - PpW){1'b0}}, pp} << {step_q, 1'b0};
    end

    pp_row_2x8 u_pp_row (
        .a2 (pair),
        .b  (b_q),
        .pp (pp)
    );

    // Next-state: accept in IDLE, accumulate in RUN, hold result in DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d  = acc_q + pp_shifted;
                step_d = step_q + StepW'(1);
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset taking priority over handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
        end
    end

    // Outputs decoded from state; P always mirrors the accumulator
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN);
        P         = acc_q;
    end

endmodule
